// File: rtl/quant_requant_seq_if.sv
// Bus bundle for the requant sequencer: config, tile control, accumulator, bias SRAM, requantizer and output buffer.
// The sequencer connects through slave and its environment through master.
interface quant_requant_seq_if #(
    parameter int LANES = 32,
    parameter int GRP_W = 8
);
    logic                    cfg_load;
    logic signed [15:0]      cfg_M;
    logic [5:0]              cfg_s;
    logic signed [7:0]       cfg_zp;
    logic [GRP_W-1:0]        cfg_groups;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    acc_valid;
    logic                    acc_ready;
    logic [LANES*32-1:0]     acc_data;
    logic                    bias_rd_en;
    logic [GRP_W-1:0]        bias_rd_addr;
    logic [LANES*32-1:0]     bias_rd_data;
    logic                    rq_en;
    logic [LANES*32-1:0]     rq_acc;
    logic [LANES*32-1:0]     rq_bias;
    logic signed [15:0]      rq_M;
    logic [5:0]              rq_s;
    logic signed [7:0]       rq_zp;
    logic                    rq_out_valid;
    logic [LANES*8-1:0]      rq_out_q;
    logic                    out_wr_en;
    logic [GRP_W-1:0]        out_wr_addr;
    logic [LANES*8-1:0]      out_wr_data;

    modport slave (
        input  cfg_load, cfg_M, cfg_s, cfg_zp, cfg_groups, start,
        input  acc_valid, acc_data, bias_rd_data, rq_out_valid, rq_out_q,
        output busy, done, err, acc_ready, bias_rd_en, bias_rd_addr,
        output rq_en, rq_acc, rq_bias, rq_M, rq_s, rq_zp,
        output out_wr_en, out_wr_addr, out_wr_data
    );

    modport master (
        output cfg_load, cfg_M, cfg_s, cfg_zp, cfg_groups, start,
        output acc_valid, acc_data, bias_rd_data, rq_out_valid, rq_out_q,
        input  busy, done, err, acc_ready, bias_rd_en, bias_rd_addr,
        input  rq_en, rq_acc, rq_bias, rq_M, rq_s, rq_zp,
        input  out_wr_en, out_wr_addr, out_wr_data
    );
endinterface

// File: rtl/quant_requant_seq.sv
// Walks the channel groups of one tile: bias read, acc pairing, requant issue, result write; 2 cycles/group, result written 1 cycle after rq_out_valid.
// Backpressure: acc_valid low stalls in ACC_WAIT holding the bias; requant results are always accepted (no stall upstream of the output buffer).
module quant_requant_seq #(
    parameter int LANES   = 32,
    parameter int GRP_W   = 8,
    parameter int OUTST_W = 4
) (
    input  logic                CLK,
    input  logic                RESETn,
    quant_requant_seq_if.slave  bus
);
    localparam int ACC_W = LANES * 32;
    localparam int Q_W   = LANES * 8;

    typedef struct packed {
        logic signed [15:0] m;
        logic [5:0]         s;
        logic signed [7:0]  zp;
        logic [GRP_W-1:0]   groups;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, BIAS_RD, ACC_WAIT, DRAIN} state_t;

    state_t               state;
    state_t               state_nxt;
    cfg_t                 cfg;
    logic [GRP_W-1:0]     g;
    logic [OUTST_W-1:0]   outst;
    logic                 bias_first;
    logic [ACC_W-1:0]     bias_q;
    logic [ACC_W-1:0]     rq_acc_q;
    logic [ACC_W-1:0]     rq_bias_q;
    logic                 rq_en_q;
    logic                 done_q;
    logic                 err_q;
    logic                 wr_en_q;
    logic [GRP_W-1:0]     wr_addr_q;
    logic [Q_W-1:0]       wr_data_q;

    logic                 start_ok;
    logic                 start_run;
    logic                 acc_hs;
    logic                 drain_ok;
    logic                 bias_rd_en_c;
    logic                 acc_ready_c;
    logic                 last_grp;
    logic                 err_set;

    assign last_grp = (g == cfg.groups - GRP_W'(1));

    always_ff @(posedge CLK) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_ok     = 1'b0;
        start_run    = 1'b0;
        acc_hs       = 1'b0;
        drain_ok     = 1'b0;
        bias_rd_en_c = 1'b0;
        acc_ready_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    start_ok = 1'b1;
                    if (cfg.groups != '0) begin
                        start_run = 1'b1;
                        state_nxt = BIAS_RD;
                    end
                end
            end
            BIAS_RD: begin
                bias_rd_en_c = 1'b1;
                state_nxt    = ACC_WAIT;
            end
            ACC_WAIT: begin
                acc_ready_c = 1'b1;
                if (bus.acc_valid) begin
                    acc_hs    = 1'b1;
                    state_nxt = last_grp ? DRAIN : BIAS_RD;
                end
            end
            DRAIN: begin
                // An issue this cycle or a result arriving now still owes a write.
                if (outst == '0 && !rq_en_q && !bus.rq_out_valid) begin
                    drain_ok  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Config only moves between tiles; a simultaneous start keeps the old set.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            cfg.m      <= '0;
            cfg.s      <= '0;
            cfg.zp     <= '0;
            cfg.groups <= GRP_W'(1);
        end else if (state == IDLE && bus.cfg_load && !bus.start) begin
            cfg <= cfg_t'({bus.cfg_M, bus.cfg_s, bus.cfg_zp, bus.cfg_groups});
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            g          <= '0;
            bias_first <= 1'b0;
            bias_q     <= '0;
            rq_en_q    <= 1'b0;
            rq_acc_q   <= '0;
            rq_bias_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            if (start_run)
                g <= '0;
            else if (acc_hs && !last_grp)
                g <= g + GRP_W'(1);

            bias_first <= bias_rd_en_c;
            if (bias_first)
                bias_q <= bus.bias_rd_data;

            rq_en_q <= acc_hs;
            if (acc_hs) begin
                rq_acc_q  <= bus.acc_data;
                rq_bias_q <= bias_first ? bus.bias_rd_data : bias_q;
            end

            done_q <= (start_ok && cfg.groups == '0) || drain_ok;
        end
    end

    assign err_set = (bus.rq_out_valid && !rq_en_q && outst == '0) ||
                     (rq_en_q && !bus.rq_out_valid && (&outst));

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            outst <= '0;
            err_q <= 1'b0;
        end else begin
            case ({rq_en_q, bus.rq_out_valid})
                2'b10:   if (!(&outst)) outst <= outst + OUTST_W'(1);
                2'b01:   if (outst != '0) outst <= outst - OUTST_W'(1);
                default: outst <= outst;
            endcase
            if (err_set)
                err_q <= 1'b1;
            else if (start_ok)
                err_q <= 1'b0;
        end
    end

    // Results are written regardless of state, including unexpected ones.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= bus.rq_out_valid;
            if (bus.rq_out_valid)
                wr_data_q <= bus.rq_out_q;
            if (start_run)
                wr_addr_q <= '0;
            else if (wr_en_q)
                wr_addr_q <= wr_addr_q + GRP_W'(1);
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.acc_ready    = acc_ready_c;
    assign bus.bias_rd_en   = bias_rd_en_c;
    assign bus.bias_rd_addr = bias_rd_en_c ? g : '0;
    assign bus.rq_en        = rq_en_q;
    assign bus.rq_acc       = rq_acc_q;
    assign bus.rq_bias      = rq_bias_q;
    assign bus.rq_M         = cfg.m;
    assign bus.rq_s         = cfg.s;
    assign bus.rq_zp        = cfg.zp;
    assign bus.out_wr_en    = wr_en_q;
    assign bus.out_wr_addr  = wr_addr_q;
    assign bus.out_wr_data  = wr_data_q;
endmodule
